// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_pkg                                                  |
// | Description : Shared definitions for the multi-port register file:         |
// |               sweep/run FSM state encoding and address-width helper.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package regfile_pkg;

  // Controller states: INIT runs the post-reset fill sweep, RUN is normal use.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Address width for a given number of entries (minimum of one bit).
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_rd_port                                              |
// | Description : One registered read port of the register file. Selects the   |
// |               addressed entry, optionally forwards a same-cycle write      |
// |               (write-first), masks the hardwired zero register and         |
// |               registers the result.                                        |
// | Config      : REGFILE_BYPASS_EN defined -> write-first, else read-first.   |
// | Ports       : clk, rst_n (async, active low)                               |
// |               run      - 1 when the file is out of its init sweep          |
// |               rd_en    - load enable of the output register                |
// |               rd_addr  - read address                                      |
// |               wr_en/wr_addr/wr_data - write port seen by the bypass        |
// |               mem      - storage array contents                            |
// |               rd_data  - registered read data                              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_IDX = 31,
  localparam int AW      = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] mem [DEPTH],
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [AW-1:0] c_zero_idx = AW'(ZERO_IDX);

  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] r_rd_data;

`ifndef REGFILE_BYPASS_EN
  // Read-first mode never looks at the write port.
  logic w_unused_wr;
  assign w_unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  always_comb begin
    w_sel = mem[rd_addr];
`ifdef REGFILE_BYPASS_EN
    // Write-first: a write landing on the address being read is forwarded.
    if (wr_en && (wr_addr == rd_addr)) begin
      w_sel = wr_data;
    end
`endif
    // Zero register wins over both the array and the forwarded data.
    w_next = w_sel;
    if ((ZERO_EN != 0) && (rd_addr == c_zero_idx)) begin
      w_next = '0;
    end
  end

  // Output only updates in RUN, so it holds the reset value of 0 through INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (run && rd_en) begin
      r_rd_data <= w_next;
    end
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_mp                                                   |
// | Description : Parametrised register file with NUM_RD registered read       |
// |               ports, one write port, optional hardwired zero register and  |
// |               a post-reset init sweep filling every entry.                 |
// | Config      : REGFILE_BYPASS_EN defined -> write-first read ports,         |
// |               undefined -> read-first.                                     |
// | Ports       : clk, rst_n (async, active low)                               |
// |               rd_en[NUM_RD], rd_addr[NUM_RD*AW]   read requests            |
// |               rd_data[NUM_RD*WIDTH]               registered read data     |
// |               wr_en, wr_addr, wr_data             write port               |
// |               init_busy                           high during the sweep    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 32,
  parameter int NUM_RD     = 2,
  parameter int ZERO_EN    = 1,
  parameter int ZERO_IDX   = 31,
  parameter int INIT_INDEX = 1,
  localparam int AW        = addr_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_RD-1:0]       rd_en,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  output logic                    init_busy
);

  localparam logic [AW-1:0] c_last_idx = AW'(DEPTH - 1);
  localparam logic [AW-1:0] c_zero_idx = AW'(ZERO_IDX);

  state_t           r_state;
  logic [AW-1:0]    r_cnt;
  logic             r_init_busy;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_run;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;

  assign w_run = (r_state == ST_RUN);

  // Sweep / run controller. init_busy is registered and drops the cycle
  // after the last entry is written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_init_busy <= 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last_idx) begin
            r_state     <= ST_RUN;
            r_init_busy <= 1'b0;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  // Single array write port, shared between the sweep and the user port.
  // The user port is ignored during INIT; the state register drops to INIT
  // on reset assertion, so no user write can complete after reset.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = wr_addr;
    w_wdata = wr_data;
    if (!w_run) begin
      w_we    = 1'b1;
      w_waddr = r_cnt;
      w_wdata = (INIT_INDEX != 0) ? WIDTH'(r_cnt) : '0;
      if ((ZERO_EN != 0) && (r_cnt == c_zero_idx)) begin
        w_wdata = '0;
      end
    end else begin
      w_we = wr_en && !((ZERO_EN != 0) && (wr_addr == c_zero_idx));
    end
  end

  // Storage has no reset; its contents are defined by the sweep.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign init_busy = r_init_busy;

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      regfile_rd_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_EN  (ZERO_EN),
        .ZERO_IDX (ZERO_IDX)
      ) u_rd_port (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (w_run),
        .rd_en   (rd_en[p]),
        .rd_addr (rd_addr[p*AW +: AW]),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .mem     (r_mem),
        .rd_data (rd_data[p*WIDTH +: WIDTH])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_regfile_mp                                                |
// | Description : Self-checking bench for regfile_mp (default parameters).     |
// |               Honours REGFILE_BYPASS_EN for the same-cycle read/write case.|
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_regfile_mp;

  localparam int WIDTH  = 64;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;
  localparam int ZIDX   = 31;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_RD-1:0]       rd_en;
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [WIDTH-1:0]        wr_data;
  logic                    init_busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  regfile_mp #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .NUM_RD     (NUM_RD),
    .ZERO_EN    (1),
    .ZERO_IDX   (ZIDX),
    .INIT_INDEX (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .init_busy (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Counts post-reset clock edges: the first DEPTH edges fill entry i with i
  // (zero register with 0); after that the file behaves as a plain array.
  logic [63:0] m_mem [DEPTH];
  logic [63:0] m_rd  [NUM_RD];
  int          m_cyc;
  logic        m_busy;
  logic [4:0]  m_a;
  logic [63:0] m_v;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc  = 0;
      m_busy = 1'b1;
      for (int p = 0; p < NUM_RD; p++) m_rd[p] = '0;
    end else if (m_cyc < DEPTH) begin
      m_mem[m_cyc] = (m_cyc == ZIDX) ? 64'd0 : 64'(m_cyc);
      m_cyc++;
      m_busy = (m_cyc < DEPTH);
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en[p]) begin
          m_a = rd_addr[p*AW +: AW];
          m_v = m_mem[m_a];
`ifdef REGFILE_BYPASS_EN
          if (wr_en && wr_addr == m_a) m_v = wr_data;
`endif
          if (m_a == ZIDX) m_v = 64'd0;
          m_rd[p] = m_v;
        end
      end
      if (wr_en && wr_addr != ZIDX) m_mem[wr_addr] = wr_data;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_rd0", rd_data[63:0],   m_rd[0]);
      check("model_rd1", rd_data[127:64], m_rd[1]);
      check("model_busy", {63'd0, init_busy}, {63'd0, m_busy});
    end
  end

  // Counts cycles with init_busy high, starting at the current negedge.
  task automatic wait_sweep(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!init_busy) break;
      n++;
      @(negedge clk);
    end
    check(name, 64'(n), 64'(DEPTH));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n   = 1'b0;
    rd_en   = '0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (3) @(negedge clk);
    check("reset_rd0", rd_data[63:0], 64'd0);
    check("reset_rd1", rd_data[127:64], 64'd0);
    check("reset_busy", {63'd0, init_busy}, 64'd1);
    chk_en = 1'b1;

    // Sweep with a write to reg 2 held throughout (must be dropped), reads off.
    wr_en   = 1'b1;
    wr_addr = 5'd2;
    wr_data = 64'h1234;
    rd_addr = {5'd9, 5'd4};
    rst_n   = 1'b1;
    wait_sweep("sweep_len");
    wr_en = 1'b0;
    check("init_rd_stable", rd_data[63:0], 64'd0);

    // Read addr 7 after the sweep.
    rd_en = 2'b01; rd_addr[4:0] = 5'd7;
    @(negedge clk);
    check("rd_addr7", rd_data[63:0], 64'd7);

    // Reg 2 still holds its sweep value; port 0 holds.
    rd_en = 2'b10; rd_addr[9:5] = 5'd2;
    @(negedge clk);
    check("init_wr_dropped", rd_data[127:64], 64'd2);
    check("hold_p0", rd_data[63:0], 64'd7);

    // Write then read the same reg on both ports.
    rd_en = 2'b00; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hDEAD_BEEF;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 2'b11; rd_addr = {5'd3, 5'd3};
    @(negedge clk);
    check("wr3_p0", rd_data[63:0],   64'hDEAD_BEEF);
    check("wr3_p1", rd_data[127:64], 64'hDEAD_BEEF);

    // Zero register ignores writes.
    rd_en = 2'b00; wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'h55;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 2'b01; rd_addr[4:0] = 5'd31;
    @(negedge clk);
    check("zero_rd", rd_data[63:0], 64'd0);
    check("zero_hold_p1", rd_data[127:64], 64'hDEAD_BEEF);
    rd_addr[4:0] = 5'd3;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'h55; rd_addr[4:0] = 5'd31;
    @(negedge clk);
    wr_en = 1'b0;
    check("zero_rw_same", rd_data[63:0], 64'd0);

    // Same-cycle write/read of reg 5.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hAA; rd_addr[4:0] = 5'd5;
    @(negedge clk);
    wr_en = 1'b0;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_rw", rd_data[63:0], 64'hAA);
`else
    check("same_cycle_rw", rd_data[63:0], 64'd5);
`endif
    @(negedge clk);
    check("after_rw", rd_data[63:0], 64'hAA);

    // Independent addresses on the two ports.
    rd_en = 2'b11; rd_addr = {5'd7, 5'd3};
    @(negedge clk);
    check("dual_p0", rd_data[63:0],   64'hDEAD_BEEF);
    check("dual_p1", rd_data[127:64], 64'd7);

    // Asynchronous reset mid-run clears the outputs at once.
    rd_en = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rd0", rd_data[63:0], 64'd0);
    check("async_rst_rd1", rd_data[127:64], 64'd0);
    check("async_rst_busy", {63'd0, init_busy}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset again when the sweep counter reaches 10.
    repeat (10) @(negedge clk);
    check("mid_sweep_busy", {63'd0, init_busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_sweep_rst_rd0", rd_data[63:0], 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_sweep("sweep_len_restart");

    // Sweep rewrote everything, including reg 3.
    rd_en = 2'b11; rd_addr = {5'd3, 5'd10};
    @(negedge clk);
    check("restart_p0", rd_data[63:0],   64'd10);
    check("restart_p1", rd_data[127:64], 64'd3);
    rd_addr = {5'd1, 5'd30};
    @(negedge clk);
    check("restart_r30", rd_data[63:0],   64'd30);
    check("restart_r1",  rd_data[127:64], 64'd1);

    rd_en = 2'b00;
    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
